// File: rtl/codon_seq_ctrl.sv
// codon_seq_ctrl: sequences codon array init/read, captures each codon into a gene word
// and hands it downstream over valid/ready until the array reports end of stream.
module codon_seq_ctrl #(
  parameter int NIB_W = 4,
  parameter int DEPTH = 6,
  parameter logic [NIB_W-1:0] TERM = 4'hF,
  parameter int READ_TIMEOUT = 8,
  parameter int CNT_W = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  output logic                            init_data_ena,
  output logic                            read_cod_ena,
  input  logic                            done_cod,
  input  logic                            done_fin,
  input  logic [DEPTH-1:0][NIB_W-1:0]     data,
  output logic                            gene_valid,
  input  logic                            gene_ready,
  output logic [DEPTH-1:0][NIB_W-1:0]     gene_data,
  output logic [$clog2(DEPTH+1)-1:0]      gene_len,
  output logic [CNT_W-1:0]                codon_cnt,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);
  localparam int LEN_W = $clog2(DEPTH+1);
  localparam int TMO_W = $clog2(READ_TIMEOUT+1);
  typedef enum logic [2:0] {IDLE, INIT, CHECK, READ, CAPTURE, OUT, FINISH, ERROR} state_e;
  state_e                      state_q, state_d;
  logic [TMO_W-1:0]            tmo_q, tmo_d;
  logic [DEPTH-1:0][NIB_W-1:0] gene_data_q, gene_data_d;
  logic [LEN_W-1:0]            gene_len_q, gene_len_d, scan_len;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        scan_stop;
  logic                        can_start;
  // Leading run of non-terminator nibbles, most significant nibble first.
  always_comb begin
    scan_len = '0;
    scan_stop = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (data[i] == TERM) scan_stop = 1'b1;
      else if (!scan_stop) scan_len = scan_len + LEN_W'(1);
    end
  end
  assign can_start = start && (state_q == IDLE || state_q == FINISH || state_q == ERROR);
  always_comb begin
    state_d = state_q;
    tmo_d = tmo_q;
    gene_data_d = gene_data_q;
    gene_len_d = gene_len_q;
    cnt_d = cnt_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (can_start) begin
      state_d = INIT;
      cnt_d = '0;
    end else begin
      case (state_q)
        INIT: state_d = CHECK;
        CHECK: begin
          state_d = done_fin ? FINISH : READ;
          tmo_d = '0;
        end
        READ: begin
          tmo_d = tmo_q + TMO_W'(1);
          state_d = done_cod ? CAPTURE : (tmo_d == TMO_W'(READ_TIMEOUT)) ? ERROR : READ;
        end
        CAPTURE: begin
          gene_data_d = data;
          gene_len_d = scan_len;
          state_d = OUT;
        end
        OUT: if (gene_ready) begin
          state_d = INIT;
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
  // Enables and valid are gated by abort so they drop in the abort cycle itself.
  always_comb begin
    init_data_ena = (state_q == INIT) && !abort;
    read_cod_ena = (state_q == READ) && !done_cod && !abort;
    gene_valid = (state_q == OUT) && !abort;
    busy = (state_q == INIT) || (state_q == CHECK) || (state_q == READ) ||
           (state_q == CAPTURE) || (state_q == OUT);
    done = (state_q == FINISH);
    err = (state_q == ERROR);
  end
  assign gene_data = gene_data_q;
  assign gene_len = gene_len_q;
  assign codon_cnt = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmo_q <= '0;
      gene_data_q <= '0;
      gene_len_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      gene_data_q <= gene_data_d;
      gene_len_q <= gene_len_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_codon_seq_ctrl.sv
// tb_codon_seq_ctrl: array model feeds random codons; a scoreboard monitor checks delivered gene words.
module tb_codon_seq_ctrl;
  localparam int NIB_W = 4;
  localparam int DEPTH = 6;
  localparam int CNT_W = 2;
  localparam int MAXC = (1 << CNT_W) - 1;
  localparam int LEN_W = $clog2(DEPTH+1);
  typedef logic [DEPTH-1:0][NIB_W-1:0] pk_t;
  typedef struct {pk_t d; int len; int cnt;} exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic init_data_ena, read_cod_ena, done_cod, done_fin, gene_valid, gene_ready;
  pk_t data, gene_data;
  logic [LEN_W-1:0] gene_len;
  logic [CNT_W-1:0] codon_cnt;
  logic busy, done, err;

  codon_seq_ctrl #(.NIB_W(NIB_W), .DEPTH(DEPTH), .TERM(4'hF), .READ_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .init_data_ena(init_data_ena), .read_cod_ena(read_cod_ena),
    .done_cod(done_cod), .done_fin(done_fin), .data(data),
    .gene_valid(gene_valid), .gene_ready(gene_ready), .gene_data(gene_data),
    .gene_len(gene_len), .codon_cnt(codon_cnt), .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  pk_t cq[$];
  int lq[$];
  exp_t sb[$];
  int ncod = 0, rds = 0, extra_reads = 0, rdy_pct = 50;
  bit rdy_force = 0;

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_len(pk_t w);
    int n = 0;
    while (n < DEPTH && w[DEPTH-1-n] != 4'hF) n++;
    return n;
  endfunction

  function automatic int sat(int n);
    return n > MAXC ? MAXC : n;
  endfunction

  function automatic pk_t rand_word();
    pk_t w;
    for (int i = 0; i < DEPTH; i++) w[i] = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    return w;
  endfunction

  task automatic add(pk_t d, int lat);
    cq.push_back(d);
    lq.push_back(lat);
  endtask

  // Codon array: loads the next queued codon on init, raises done_cod after lat reads, done_fin when empty.
  pk_t cur = '0;
  int lat = 0;
  bit active = 0, fired = 0, fin = 0;
  initial begin
    done_cod = 0; done_fin = 0; data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || abort) begin
        active = 0; fin = 0;
      end else if (init_data_ena) begin
        fin = (cq.size() == 0);
        active = !fin; fired = 0; rds = 0;
        if (!fin) begin cur = cq.pop_front(); lat = lq.pop_front(); end
      end else if (read_cod_ena) begin
        rds++;
        if (fin) extra_reads++;
      end
      @(posedge clk); #1;
      data = cur;
      done_fin = fin;
      done_cod = active && rds >= lat;
      if (done_cod && !fired) begin
        fired = 1;
        ncod++;
        sb.push_back('{cur, ref_len(cur), sat(ncod)});
      end
    end
  end

  initial begin
    gene_ready = 0;
    forever begin
      @(posedge clk); #1;
      gene_ready = rdy_force || ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Monitor: every valid cycle must show the head expectation; after an accept check count and next init.
  bit chk_cnt = 0;
  int exp_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (chk_cnt) begin
      chk("codon_cnt", codon_cnt, exp_cnt);
      chk("valid_drop", gene_valid, 0);
      chk("next_init", init_data_ena, 1);
      chk_cnt = 0;
    end else if (gene_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        chk("gene_data", gene_data, sb[0].d);
        chk("gene_len", gene_len, sb[0].len);
        if (gene_ready) begin
          exp_cnt = sb[0].cnt;
          void'(sb.pop_front());
          chk_cnt = 1;
        end
      end
    end
  end

  task automatic start_run();
    ncod = 0;
    extra_reads = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_end();
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = done || err;
    end
    chk("wait_end", ok, 1);
  endtask

  task automatic finish_check(int n);
    wait_end();
    chk("done", done, 1);
    chk("err", err, 0);
    chk("busy_finish", busy, 0);
    chk("cnt_finish", codon_cnt, sat(n));
    chk("no_read_after_fin", extra_reads, 0);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    bit seen;
    #3;
    chk("rst_init", init_data_ena, 0);
    chk("rst_read", read_cod_ena, 0);
    chk("rst_valid", gene_valid, 0);
    chk("rst_data", gene_data, 0);
    chk("rst_len", gene_len, 0);
    chk("rst_cnt", codon_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Nominal plus length boundaries and count saturation.
    add(24'h123F00, 4);
    add(24'h9A8B7C, 3);
    add(24'hF12345, 2);
    add(rand_word(), 1);
    add(rand_word(), 7);
    start_run();
    finish_check(5);

    // Two codons; a start while busy must be ignored.
    add(rand_word(), 2);
    add(rand_word(), 5);
    start_run();
    repeat (3) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    finish_check(2);

    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 6);
      rdy_pct = (r % 2) ? 15 : 70;
      for (int k = 0; k < n; k++) add(rand_word(), $urandom_range(1, 7));
      start_run();
      finish_check(n);
    end
    rdy_pct = 50;

    // Read timeout, then restart out of ERROR.
    add(rand_word(), 1000);
    start_run();
    wait_end();
    chk("err_set", err, 1);
    chk("err_done", done, 0);
    chk("err_busy", busy, 0);
    chk("err_read", read_cod_ena, 0);
    chk("timeout_reads", rds, 8);
    add(rand_word(), 3);
    ncod = 0;
    @(posedge clk); #1 start = 1;
    @(negedge clk);
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    chk("restart_init", init_data_ena, 1);
    chk("restart_err", err, 0);
    finish_check(1);

    // Abort in the OUT cycle with ready high.
    rdy_force = 1;
    add(24'h4567F0, 2);
    add(rand_word(), 2);
    start_run();
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = done_cod;
    end
    chk("abort_wait", seen, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 1;
    @(negedge clk);
    chk("abort_valid", gene_valid, 0);
    chk("abort_cnt", codon_cnt, 0);
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_cnt_after", codon_cnt, 0);
    chk("abort_keep_data", gene_data, 24'h4567F0);
    chk("abort_init", init_data_ena, 0);
    sb.delete(); cq.delete(); lq.delete();
    rdy_force = 0;

    // Asynchronous reset in the middle of READ.
    add(rand_word(), 1000);
    start_run();
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = read_cod_ena;
    end
    chk("read_seen", seen, 1);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("arst_read", read_cod_ena, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", gene_data, 0);
    chk("arst_len", gene_len, 0);
    chk("arst_cnt", codon_cnt, 0);
    chk("arst_valid", gene_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    sb.delete(); cq.delete(); lq.delete();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/codon_seq_ctrl.md
Name: codon_seq_ctrl

Overview:
Sequencer for the codon array shift register. It pulses the array's init enable, holds its read enable until the array flags a complete codon, and captures the array contents into a stable gene word. The word goes to a downstream consumer over a valid/ready handshake. The block loops over codons until the array reports end-of-file, and sits between the top-level start/status logic and the codon array.

Parameters:
NIB_W, 4, width of one codon nibble
DEPTH, 6, number of nibbles in the array data word
TERM, 4'hF, terminator nibble value
READ_TIMEOUT, 8, maximum READ cycles before error (must be > DEPTH)
CNT_W, 8, width of the codon counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start request; accepted only in IDLE, FINISH or ERROR
abort  in  1  synchronous abort; returns to IDLE next cycle
init_data_ena  out  1  to array: clear/init strobe
read_cod_ena  out  1  to array: shift-in enable
done_cod  in  1  from array: codon complete (terminator seen)
done_fin  in  1  from array: end of codon stream
data  in  DEPTH x NIB_W (packed [DEPTH-1:0][NIB_W-1:0])  from array: codon nibbles, data[DEPTH-1] first
gene_valid  out  1  gene word available
gene_ready  in  1  consumer accepts gene word
gene_data  out  DEPTH x NIB_W  captured codon word
gene_len  out  $clog2(DEPTH+1)  non-terminator nibbles in gene_data, 0..DEPTH
codon_cnt  out  CNT_W  codons delivered since last start
busy  out  1  high in INIT, CHECK, READ, CAPTURE, OUT
done  out  1  sticky end-of-stream flag
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n=0, async): state=IDLE. All outputs 0, including gene_data, gene_len and codon_cnt.
- States: IDLE, INIT, CHECK, READ, CAPTURE, OUT, FINISH, ERROR.
- IDLE: start -> INIT. On entry from start, clear codon_cnt, done and err.
- INIT: init_data_ena=1 for exactly one cycle -> CHECK.
- CHECK: one cycle with no enables; sample done_fin. If done_fin=1 -> FINISH, else -> READ and clear the timeout counter.
- READ: read_cod_ena=1 every cycle and increment the timeout counter.
  - done_cod=1 -> CAPTURE; read_cod_ena drops in the same cycle via combinational decode of state and done_cod.
  - Counter reaching READ_TIMEOUT without done_cod -> ERROR.
  - done_cod takes priority over timeout in the same cycle.
- CAPTURE: register gene_data<=data.
  - gene_len = count of consecutive non-TERM nibbles scanning from index DEPTH-1 downward, stopping at the first TERM.
  - All non-TERM gives DEPTH; data[DEPTH-1]==TERM gives 0.
  - Next state: OUT.
- OUT: gene_valid=1.
  - gene_data and gene_len are held stable while gene_valid=1 and gene_ready=0.
  - On gene_valid && gene_ready: codon_cnt increments, saturating at 2^CNT_W-1, then -> INIT. gene_valid is low the following cycle.
  - A zero-length codon (gene_len=0) is still delivered.
- FINISH: done=1, busy=0; start -> INIT (clears done and codon_cnt).
- ERROR: err=1, busy=0; start -> INIT (clears err and codon_cnt).
- abort: from any state -> IDLE next cycle. Enables and gene_valid drop that cycle; done, err and codon_cnt are cleared; gene_data is kept.
- Priorities: abort beats start; start while busy is ignored; abort beats handshake completion.
- Enables are mutually exclusive: init_data_ena and read_cod_ena are never high in the same cycle.
- Reset mid-READ: read_cod_ena drops asynchronously with rst_n.
- Latency: start to first init_data_ena is 1 cycle. done_cod to gene_valid is 2 cycles (CAPTURE, then OUT).

Test Plan:
- Nominal codon: start; array returns data={1,2,3,F,0,0}; done_cod after 4 READ cycles -> gene_valid 2 cycles later, gene_data matches, gene_len=3; ready=1 -> codon_cnt=1, next init_data_ena 1 cycle later.
- Backpressure: gene_ready low 5 cycles in OUT -> gene_valid/gene_data/gene_len stable for all 5; single codon_cnt increment on accept.
- End of stream: after 2 codons, done_fin=1 at CHECK -> FINISH, done=1, busy=0, codon_cnt=2, no read_cod_ena pulse.
- Timeout: done_cod never asserted -> err=1 after exactly 8 READ cycles, read_cod_ena low in ERROR; start -> err cleared, init_data_ena pulses.
- Boundaries: data all non-TERM -> gene_len=6; data[5]=F -> gene_len=0 still delivered; CNT_W=2 with 5 codons -> codon_cnt saturates at 3.
- Abort/reset: abort during OUT with gene_ready=1 same cycle -> no increment, IDLE next cycle, gene_valid=0; rst_n low mid-READ -> all outputs 0 immediately.
